uart_tx: RTL and testbench

UART_TX -- requirements
Module: uart_tx

---
 rtl/uart_tx.sv | 134 +++++++++++++
 tb/tb_uart_tx.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx.sv
// 8N1 UART transmitter with an internal byte FIFO and a runtime-loadable bit period.
// Line changes one cycle after the popping edge; tx_wr_i is dropped silently when the FIFO is full.
module uart_tx #(
  parameter int BAUD_RATE  = 115200,
  parameter int CLK_FREQ   = 50000000,
  parameter int FIFO_DEPTH = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        wr_bit_period_i,
  input  logic [15:0] bit_period_i,
  input  logic        uart_tx_en,
  input  logic        tx_wr_i,
  input  logic [7:0]  tx_data_i,
  output logic        tx_full_o,
  output logic        tx_empty_o,
  output logic        tx_busy_o,
  output logic        uart_txd
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [15:0] DEFAULT_P = 16'(CLK_FREQ / BAUD_RATE - 1);
  localparam logic [AW:0] DEPTH_C = (AW + 1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t       state, state_nxt;
  logic [15:0]  bit_period;
  logic [15:0]  cnt, cnt_nxt;
  logic [2:0]   idx, idx_nxt, idx_inc;
  logic [7:0]   sh, sh_nxt;
  logic         txd, txd_nxt;
  logic         pop, push;

  logic [7:0]   mem [FIFO_DEPTH];
  logic [AW-1:0] wptr, rptr;
  logic [AW:0]  count;

  assign tx_full_o  = (count == DEPTH_C);
  assign tx_empty_o = (count == '0);
  assign tx_busy_o  = (state != IDLE);
  assign uart_txd   = txd;
  assign push       = tx_wr_i && !tx_full_o;
  assign idx_inc    = idx + 3'd1;

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    idx_nxt   = idx;
    sh_nxt    = sh;
    txd_nxt   = txd;
    pop       = 1'b0;
    // A bit-period load aborts the frame in flight and suppresses any pop that edge
    if (wr_bit_period_i) begin
      state_nxt = IDLE;
      cnt_nxt   = '0;
      idx_nxt   = '0;
      txd_nxt   = 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (uart_tx_en && !tx_empty_o) begin
            pop       = 1'b1;
            sh_nxt    = mem[rptr];
            txd_nxt   = 1'b0;
            cnt_nxt   = bit_period;
            idx_nxt   = '0;
            state_nxt = START;
          end
        end
        START: begin
          if (cnt != '0) begin
            cnt_nxt = cnt - 16'd1;
          end else begin
            txd_nxt   = sh[0];
            cnt_nxt   = bit_period;
            state_nxt = DATA;
          end
        end
        DATA: begin
          if (cnt != '0) begin
            cnt_nxt = cnt - 16'd1;
          end else if (idx != 3'd7) begin
            idx_nxt = idx_inc;
            txd_nxt = sh[idx_inc];
            cnt_nxt = bit_period;
          end else begin
            txd_nxt   = 1'b1;
            cnt_nxt   = bit_period;
            state_nxt = STOP;
          end
        end
        STOP: begin
          if (cnt != '0) cnt_nxt = cnt - 16'd1;
          else           state_nxt = IDLE;
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      idx        <= '0;
      sh         <= '0;
      txd        <= 1'b1;
      bit_period <= DEFAULT_P;
      wptr       <= '0;
      rptr       <= '0;
      count      <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      idx   <= idx_nxt;
      sh    <= sh_nxt;
      txd   <= txd_nxt;
      if (wr_bit_period_i) bit_period <= bit_period_i;
      if (push) wptr <= AW'(wptr + 1);
      if (pop)  rptr <= AW'(rptr + 1);
      case ({push, pop})
        2'b10:   count <= (AW + 1)'(count + 1);
        2'b01:   count <= (AW + 1)'(count - 1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n && push) mem[wptr] <= tx_data_i;
  end

endmodule

// File: tb/tb_uart_tx.sv
// Randomised and directed bench for uart_tx against a frame-level reference model.
module tb_uart_tx;
  localparam int DEPTH = 8;
  localparam int DEF_P = 50000000 / 115200 - 1;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        wr_bit_period_i = 1'b0;
  logic [15:0] bit_period_i = '0;
  logic        uart_tx_en = 1'b0;
  logic        tx_wr_i = 1'b0;
  logic [7:0]  tx_data_i = '0;
  logic        tx_full_o, tx_empty_o, tx_busy_o, uart_txd;

  always #5 clk = ~clk;

  uart_tx #(.BAUD_RATE(115200), .CLK_FREQ(50000000), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .wr_bit_period_i(wr_bit_period_i), .bit_period_i(bit_period_i),
    .uart_tx_en(uart_tx_en), .tx_wr_i(tx_wr_i), .tx_data_i(tx_data_i), .tx_full_o(tx_full_o),
    .tx_empty_o(tx_empty_o), .tx_busy_o(tx_busy_o), .uart_txd(uart_txd)
  );

  int n_checks = 0;
  int n_fail = 0;

  // Reference model: byte queue plus "cycles left in current frame"
  logic [7:0] mq[$];
  int         m_left = 0;
  int         m_p = DEF_P;
  int         m_fp = DEF_P;
  logic [7:0] m_cur = '0;

  logic       line_q[$];
  logic [7:0] dec_q[$];
  logic [7:0] wq[$];
  int         busy_cycles = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic m_line();
    int el, b;
    if (m_left == 0) return 1'b1;
    el = 10 * (m_fp + 1) - m_left;
    b  = el / (m_fp + 1);
    if (b == 0) return 1'b0;
    if (b <= 8) return m_cur[b-1];
    return 1'b1;
  endfunction

  task automatic step();
    bit full0, do_pop;
    logic [3:0] exp;
    @(posedge clk);
    if (!rst_n) begin
      mq.delete();
      m_left = 0;
      m_p = DEF_P;
    end else begin
      full0  = (mq.size() == DEPTH);
      do_pop = (m_left == 0) && uart_tx_en && (mq.size() > 0) && !wr_bit_period_i;
      if (wr_bit_period_i) begin
        m_left = 0;
        m_p = int'(bit_period_i);
      end else if (m_left > 0) begin
        m_left--;
      end
      if (do_pop) begin
        m_cur  = mq.pop_front();
        m_fp   = m_p;
        m_left = 10 * (m_p + 1);
      end
      if (tx_wr_i && !full0) mq.push_back(tx_data_i);
    end
    #1;
    exp = {m_line(), m_left > 0, mq.size() == 0, mq.size() == DEPTH};
    check("outs", 32'({uart_txd, tx_busy_o, tx_empty_o, tx_full_o}), 32'(exp));
    line_q.push_back(uart_txd);
    if (tx_busy_o) busy_cycles++;
  endtask

  task automatic idle(input int n);
    repeat (n) step();
  endtask

  task automatic push(input logic [7:0] d);
    tx_wr_i = 1'b1;
    tx_data_i = d;
    step();
    tx_wr_i = 1'b0;
  endtask

  task automatic set_p(input int p);
    wr_bit_period_i = 1'b1;
    bit_period_i = 16'(p);
    step();
    wr_bit_period_i = 1'b0;
  endtask

  // Recover bytes from the recorded line by sampling mid-bit after each start edge
  task automatic decode(input int p);
    int i;
    logic [7:0] b;
    dec_q.delete();
    i = 0;
    while (i < line_q.size()) begin
      if (line_q[i] == 1'b0 && i + 10 * (p + 1) <= line_q.size()) begin
        for (int k = 0; k < 8; k++) b[k] = line_q[i + (k + 1) * (p + 1) + p / 2];
        dec_q.push_back(b);
        i += 10 * (p + 1);
      end else begin
        i++;
      end
    end
  endtask

  task automatic check_decoded(input string tag, input int p);
    decode(p);
    check({tag, "_count"}, 32'(dec_q.size()), 32'(wq.size()));
    for (int k = 0; k < wq.size() && k < dec_q.size(); k++)
      check($sformatf("%s_byte%0d", tag, k), 32'(dec_q[k]), 32'(wq[k]));
  endtask

  initial begin
    int seq_a5[10] = '{0, 1, 0, 1, 0, 0, 1, 0, 1, 1};
    int zeros;

    // Reset, with load and write strobes that reset must override
    tx_wr_i = 1'b1; tx_data_i = 8'h11;
    wr_bit_period_i = 1'b1; bit_period_i = 16'd5;
    idle(2);
    check("rst_txd", 32'(uart_txd), 32'd1);
    check("rst_busy", 32'(tx_busy_o), 32'd0);
    check("rst_empty", 32'(tx_empty_o), 32'd1);
    check("rst_full", 32'(tx_full_o), 32'd0);
    tx_wr_i = 1'b0; wr_bit_period_i = 1'b0; bit_period_i = '0;
    rst_n = 1'b1;
    idle(2);

    // Default period, 0xA5
    uart_tx_en = 1'b1;
    line_q.delete(); busy_cycles = 0;
    push(8'hA5);
    idle(4345);
    for (int k = 0; k < 10; k++) begin
      check($sformatf("a5_bit%0d_first", k), 32'(line_q[1 + k * 434]), 32'(seq_a5[k]));
      check($sformatf("a5_bit%0d_last", k), 32'(line_q[1 + k * 434 + 433]), 32'(seq_a5[k]));
    end
    check("a5_idle_after", 32'(line_q[1 + 4340]), 32'd1);
    check("a5_busy_cycles", 32'(busy_cycles), 32'd4340);

    // Fill while disabled, overflow write dropped, then drain in order
    set_p(3);
    uart_tx_en = 1'b0;
    wq.delete();
    for (int k = 0; k < 8; k++) begin
      wq.push_back(8'($urandom));
      push(wq[k]);
    end
    check("full_after8", 32'(tx_full_o), 32'd1);
    push(8'hEE);
    check("full_after9", 32'(tx_full_o), 32'd1);
    line_q.delete();
    uart_tx_en = 1'b1;
    idle(8 * 41 + 5);
    check("drain_empty", 32'(tx_empty_o), 32'd1);
    check("drain_busy", 32'(tx_busy_o), 32'd0);
    check_decoded("drain", 3);

    // Period load mid-DATA aborts 0x3C; 0x81 follows at the new period
    set_p(7);
    push(8'h3C);
    push(8'h81);
    idle(12);
    wr_bit_period_i = 1'b1; bit_period_i = 16'd3;
    step();
    wr_bit_period_i = 1'b0;
    check("abort_txd", 32'(uart_txd), 32'd1);
    check("abort_busy", 32'(tx_busy_o), 32'd0);
    line_q.delete();
    idle(50);
    wq.delete(); wq.push_back(8'h81);
    check_decoded("after_abort", 3);

    // Push coincident with pop on a full FIFO is dropped
    uart_tx_en = 1'b0;
    wq.delete();
    for (int k = 0; k < 8; k++) begin
      wq.push_back(8'($urandom));
      push(wq[k]);
    end
    line_q.delete();
    uart_tx_en = 1'b1;
    push(8'h77);
    check("full_pop_push_full", 32'(tx_full_o), 32'd0);
    idle(8 * 41 + 5);
    check_decoded("full_pop_push", 3);

    // Reset during STOP with three bytes still queued
    uart_tx_en = 1'b0;
    for (int k = 0; k < 4; k++) push(8'($urandom));
    uart_tx_en = 1'b1;
    idle(38);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    check("stop_rst_txd", 32'(uart_txd), 32'd1);
    check("stop_rst_empty", 32'(tx_empty_o), 32'd1);
    check("stop_rst_busy", 32'(tx_busy_o), 32'd0);
    line_q.delete();
    idle(60);
    zeros = 0;
    foreach (line_q[i]) if (line_q[i] == 1'b0) zeros++;
    check("stop_rst_quiet", 32'(zeros), 32'd0);

    // One cycle per bit
    set_p(0);
    line_q.delete(); busy_cycles = 0;
    push(8'hFF);
    idle(14);
    zeros = 0;
    foreach (line_q[i]) if (line_q[i] == 1'b0) zeros++;
    check("p0_zeros", 32'(zeros), 32'd1);
    check("p0_start", 32'(line_q[1]), 32'd0);
    check("p0_busy_cycles", 32'(busy_cycles), 32'd10);

    // Random traffic, period loads and resets against the model
    set_p(2);
    for (int c = 0; c < 5000; c++) begin
      tx_wr_i = ($urandom_range(0, 99) < 30);
      tx_data_i = 8'($urandom);
      if ($urandom_range(0, 19) == 0) uart_tx_en = ~uart_tx_en;
      wr_bit_period_i = ($urandom_range(0, 299) == 0);
      bit_period_i = 16'($urandom_range(0, 5));
      rst_n = !($urandom_range(0, 1499) == 0);
      step();
    end
    tx_wr_i = 1'b0; wr_bit_period_i = 1'b0; rst_n = 1'b1;
    idle(5);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
